bounce_gen_module: RTL and testbench

BOUNCE_GEN_MODULE -- requirements
Module: bounce_gen_module

---
 rtl/bounce_gen_pkg.sv | 26 ++
 rtl/bounce_gen_lfsr16.sv | 36 +++
 rtl/bounce_gen_module.sv | 166 ++++++++++++++++
 tb/tb_bounce_gen_module.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_gen_pkg.sv
// -----------------------------------------------------------------------------
// bounce_gen_pkg
// Shared definitions for the bounce generator: FSM state encoding, the
// 16-bit Galois LFSR geometry (width, tap mask, seed) and its step function.
// Optional feature macro used by the block: BOUNCE_GEN_RAND_EN.
// -----------------------------------------------------------------------------
package bounce_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_e;

  localparam int          LFSR_W    = 16;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One LFSR step. The map is a bijection on non-zero states, so starting
  // from a non-zero seed the all-zero state can never be reached.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16_module
// Free-running 16-bit Galois LFSR, advancing every clock, seeded on reset.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - asynchronous active-high reset (loads LFSR_SEED)
//   lfsr_o  - low OUT_W bits of the current LFSR state
// -----------------------------------------------------------------------------
module lfsr16_module
  import bounce_gen_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [OUT_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/bounce_gen_module.sv
// -----------------------------------------------------------------------------
// bounce_gen_module
// Emulates a bouncing mechanical contact. When the clean Level_In differs from
// the stored target while idle, Pin_Out jumps to the new level, then toggles
// 2*N more times with a segment of 'gap' cycles between toggles, holds for
// SETTLE_CYC cycles and pulses Done. Input changes while busy are ignored and
// re-evaluated on the first idle cycle.
//
// Optional feature macro: BOUNCE_GEN_RAND_EN
//   defined   : N and gap are drawn from a 16-bit LFSR (lfsr16_module)
//   undefined : N = BOUNCE_MAX, gap = GAP_FIX, no LFSR, fully deterministic
//
// Ports:
//   CLK      - clock, rising edge
//   RST      - asynchronous active-high reset
//   Level_In - clean target level, already synchronous to CLK
//   Pin_Out  - emulated bouncing pin (registered)
//   Busy     - high while a transition is being emulated
//   Done     - one-cycle pulse once Pin_Out has settled
// -----------------------------------------------------------------------------
module bounce_gen_module
  import bounce_gen_pkg::*;
#(
  parameter int BOUNCE_MAX = 4,
  parameter int GAP_FIX    = 3,
  parameter int GAP_W      = 8,
  parameter int SETTLE_CYC = 1000
) (
  input  logic CLK,
  input  logic RST,
  input  logic Level_In,
  output logic Pin_Out,
  output logic Busy,
  output logic Done
);

  // Counter widths cover the largest legal load value so nothing wraps.
  localparam int GAP_RND_MAX = 2 ** GAP_W;
  localparam int GAP_MAX     = (GAP_RND_MAX > GAP_FIX) ? GAP_RND_MAX : GAP_FIX;
  localparam int GAP_CW      = $clog2(GAP_MAX + 1);
  localparam int TOG_MAX     = 2 * BOUNCE_MAX;
  localparam int TOG_CW      = $clog2(TOG_MAX + 1);
  localparam int SET_CW      = $clog2(SETTLE_CYC + 1);

  logic [GAP_CW-1:0] gap_val;   // segment length for the next load
  logic [TOG_CW-1:0] tog_load;  // 2*N, toggles for a new burst

`ifdef BOUNCE_GEN_RAND_EN
  localparam int RND_W = (GAP_W > 8) ? GAP_W : 8;

  logic [RND_W-1:0] rnd;
  logic [7:0]       n_minus1;

  lfsr16_module #(
    .OUT_W (RND_W)
  ) u_lfsr (
    .clk_i  (CLK),
    .rst_i  (RST),
    .lfsr_o (rnd)
  );

  // N-1 = lfsr[7:0] masked to BOUNCE_MAX-1 (power of two), so 2*N = 2*(N-1)+2.
  assign n_minus1 = rnd[7:0] & 8'(BOUNCE_MAX - 1);
  assign tog_load = TOG_CW'({n_minus1, 1'b0}) + TOG_CW'(2);
  assign gap_val  = GAP_CW'(rnd[GAP_W-1:0]) + GAP_CW'(1);
`else
  assign tog_load = TOG_CW'(TOG_MAX);
  assign gap_val  = GAP_CW'(GAP_FIX);
`endif

  state_e            state_q,   state_d;
  logic              target_q,  target_d;
  logic              pin_q,     pin_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic [GAP_CW-1:0] gap_cnt_q, gap_cnt_d;
  logic [TOG_CW-1:0] tog_cnt_q, tog_cnt_d;
  logic [SET_CW-1:0] set_cnt_q, set_cnt_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      target_q  <= 1'b0;
      pin_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gap_cnt_q <= '0;
      tog_cnt_q <= '0;
      set_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      pin_q     <= pin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      gap_cnt_q <= gap_cnt_d;
      tog_cnt_q <= tog_cnt_d;
      set_cnt_q <= set_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    pin_d     = pin_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    gap_cnt_d = gap_cnt_q;
    tog_cnt_d = tog_cnt_q;
    set_cnt_d = set_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (Level_In != target_q) begin
          target_d  = Level_In;
          pin_d     = Level_In;
          busy_d    = 1'b1;
          gap_cnt_d = gap_val;
          tog_cnt_d = tog_load;
          state_d   = BOUNCE;
        end
      end

      BOUNCE: begin
        // Counter holds the cycles left in the current segment; the toggle
        // happens on the edge that ends the segment's last cycle.
        if (gap_cnt_q == GAP_CW'(1)) begin
          pin_d     = ~pin_q;
          tog_cnt_d = tog_cnt_q - TOG_CW'(1);
          if (tog_cnt_q == TOG_CW'(1)) begin
            gap_cnt_d = '0;
            set_cnt_d = SET_CW'(SETTLE_CYC);
            state_d   = SETTLE;
          end else begin
            gap_cnt_d = gap_val;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_CW'(1);
        end
      end

      SETTLE: begin
        // The Done cycle is spent in SETTLE so Busy drops one cycle later
        // and the first IDLE cycle re-compares Level_In.
        if (done_q) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (set_cnt_q == SET_CW'(1)) begin
          done_d    = 1'b1;
          set_cnt_d = '0;
        end else begin
          set_cnt_d = set_cnt_q - SET_CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Pin_Out = pin_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_bounce_gen_module.sv
// -----------------------------------------------------------------------------
// tb_bounce_gen_module
// Deterministic build: a vector table of {level, hold, expected end state}
// drives Level_In; each accepted transition pushes its expected per-cycle
// waveform into a scoreboard queue that is popped and compared every cycle.
// Randomised build (BOUNCE_GEN_RAND_EN): burst-shape properties over 200
// transitions.
// -----------------------------------------------------------------------------
module tb_bounce_gen_module;

  localparam int BM       = 2;
  localparam int GF       = 3;
  localparam int GW       = 4;
  localparam int SC       = 5;
  localparam int TOG      = 2 * BM;
  localparam int DONE_OFS = 1 + TOG * GF + SC;

  logic CLK      = 1'b0;
  logic RST      = 1'b1;
  logic Level_In = 1'b0;
  logic Pin_Out;
  logic Busy;
  logic Done;

  bounce_gen_module #(
    .BOUNCE_MAX (BM),
    .GAP_FIX    (GF),
    .GAP_W      (GW),
    .SETTLE_CYC (SC)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Level_In (Level_In),
    .Pin_Out  (Pin_Out),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic pin;
    logic busy;
    logic done;
  } obs_t;

  typedef struct {
    logic  level;
    int    hold;
    logic  exp_pin;
    logic  exp_busy;
    int    exp_dones;
    string name;
  } vec_t;

  obs_t  exp_q[$];
  vec_t  vecs[11];
  int    checks        = 0;
  int    errors        = 0;
  int    cyc           = 0;
  int    dones_seen    = 0;
  logic  tgt_model     = 1'b0;
  logic  last_busy_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h required %0h", name, cyc, got, want);
    end
  endtask

  // Expected waveform of one emulation, offsets 1..DONE_OFS after the
  // sampling cycle: new level at 1, a toggle every GF cycles, Done at the end.
  task automatic push_emulation(input logic lvl);
    obs_t e;
    int   t;
    for (int o = 1; o <= DONE_OFS; o++) begin
      t = (o - 1) / GF;
      if (t > TOG) t = TOG;
      e.pin  = lvl ^ t[0];
      e.busy = 1'b1;
      e.done = (o == DONE_OFS);
      exp_q.push_back(e);
    end
  endtask

  // Drive Level_In for the current cycle; the block accepts it at the next
  // edge only if it is idle now and the level differs from the target.
  task automatic set_level(input logic lvl);
    Level_In = lvl;
    if (!RST && !last_busy_exp && (lvl != tgt_model)) begin
      push_emulation(lvl);
      tgt_model = lvl;
    end
  endtask

  task automatic tick();
    obs_t act;
    obs_t exp;
    @(posedge CLK);
    #1;
    cyc++;
    act = {Pin_Out, Busy, Done};
    if (RST)                   exp = '0;
    else if (exp_q.size() > 0) exp = exp_q.pop_front();
    else                       exp = {tgt_model, 1'b0, 1'b0};
    last_busy_exp = exp.busy;
    if (Done === 1'b1) dones_seen++;
    check("pin_busy_done", 32'(act), 32'(exp));
  endtask

  task automatic run_vec(input vec_t v);
    int d0;
    d0 = dones_seen;
    for (int h = 0; h < v.hold; h++) begin
      set_level(v.level);
      tick();
    end
    check({v.name, "_pin"},   32'(Pin_Out), 32'(v.exp_pin));
    check({v.name, "_busy"},  32'(Busy),    32'(v.exp_busy));
    check({v.name, "_dones"}, 32'(dones_seen - d0), 32'(v.exp_dones));
    $display("vec %-16s level=%0d hold=%0d pin=%0d busy=%0d dones=%0d cycle=%0d",
             v.name, v.level, v.hold, Pin_Out, Busy, dones_seen - d0, cyc);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic async_reset(input string name);
    #2 RST = 1'b1;
    #1;
    check({name, "_async_pin"},  32'(Pin_Out), 32'(0));
    check({name, "_async_busy"}, 32'(Busy),    32'(0));
    check({name, "_async_done"}, 32'(Done),    32'(0));
    exp_q.delete();
    tgt_model     = 1'b0;
    last_busy_exp = 1'b0;
    $display("reset %s asserted at cycle %0d", name, cyc);
  endtask

`ifdef BOUNCE_GEN_RAND_EN
  task automatic random_test();
    logic lvl;
    logic prev;
    int   changes;
    int   since;
    int   budget;
    bit   got_done;
    lvl    = 1'b0;
    budget = TOG * (2 ** GW) + SC + 10;
    for (int k = 0; k < 200; k++) begin
      lvl      = ~lvl;
      Level_In = lvl;
      prev     = Pin_Out;
      changes  = 0;
      since    = 0;
      got_done = 1'b0;
      for (int c = 0; c < budget && !got_done; c++) begin
        @(posedge CLK);
        #1;
        cyc++;
        since++;
        if (Pin_Out !== prev) begin
          changes++;
          if (changes > 1) begin
            checks++;
            if (since < 1 || since > 2 ** GW) begin
              errors++;
              $display("FAIL gap_range burst %0d got %0d required 1..%0d", k, since, 2 ** GW);
            end
          end
          since = 0;
          prev  = Pin_Out;
        end
        if (Done === 1'b1) got_done = 1'b1;
      end
      check("done_seen", 32'(got_done), 32'(1));
      checks++;
      if (((changes - 1) % 2) != 0 || (changes - 1) < 2 || (changes - 1) > TOG) begin
        errors++;
        $display("FAIL toggle_count burst %0d got %0d required even 2..%0d", k, changes - 1, TOG);
      end
      check("pin_at_done", 32'(Pin_Out), 32'(lvl));
      @(posedge CLK);
      #1;
      cyc++;
      check("busy_after_done", 32'(Busy), 32'(0));
      $display("burst %0d level=%0d toggles=%0d cycle=%0d", k, lvl, changes - 1, cyc);
    end
  endtask
`endif

  initial begin
    int d0;

    //           level hold pin  busy dones name
    vecs[0]  = '{1'b0,  5, 1'b0, 1'b0, 0, "idle_low"};
    vecs[1]  = '{1'b1, 25, 1'b1, 1'b0, 1, "rise"};
    vecs[2]  = '{1'b0, 25, 1'b0, 1'b0, 1, "fall"};
    vecs[3]  = '{1'b1,  5, 1'b0, 1'b1, 0, "rise_start"};
    vecs[4]  = '{1'b0,  3, 1'b1, 1'b1, 0, "glitch_low"};
    vecs[5]  = '{1'b1, 20, 1'b1, 1'b0, 1, "glitch_revert"};
    vecs[6]  = '{1'b0,  4, 1'b1, 1'b1, 0, "fall_start"};
    vecs[7]  = '{1'b1, 40, 1'b1, 1'b0, 2, "held_change"};
    vecs[8]  = '{1'b0, 18, 1'b0, 1'b1, 1, "fall_to_done"};
    vecs[9]  = '{1'b1,  1, 1'b0, 1'b0, 0, "change_at_done"};
    vecs[10] = '{1'b1, 25, 1'b1, 1'b0, 1, "rise_after_done"};

    // Reset state
    RST      = 1'b1;
    Level_In = 1'b0;
    tick();
    tick();
    check("reset_pin",  32'(Pin_Out), 32'(0));
    check("reset_busy", 32'(Busy),    32'(0));
    check("reset_done", 32'(Done),    32'(0));
    RST = 1'b0;

`ifdef BOUNCE_GEN_RAND_EN
    random_test();
`else
    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while idle at level 1, then abort a 0->1 burst mid-bounce.
    Level_In = 1'b0;
    async_reset("idle");
    tick();
    tick();
    RST = 1'b0;
    for (int h = 0; h < 3; h++) begin
      set_level(1'b0);
      tick();
    end
    for (int h = 0; h < 8; h++) begin
      set_level(1'b1);
      tick();
    end
    check("mid_bounce_pin", 32'(Pin_Out), 32'(1));
    d0 = dones_seen;
    async_reset("mid_bounce");
    for (int h = 0; h < 3; h++) tick();
    check("abort_no_done", 32'(dones_seen - d0), 32'(0));
    RST = 1'b0;
    run_vec('{1'b1, 25, 1'b1, 1'b0, 1, "post_reset_rise"});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
